th99_bus_if: RTL

Host-bus front end for the TH99CHLS core. Sits directly upstream of the core's register and display logic. It synchronises the asynchronous 8051-style multiplexed bus (abus = high address, dbus = low address/data, ale, r_n, w_n, cs_n) into the `clock` domain. It latches the 16-bit address and turns each bus cycle into a single-cycle write strobe or a read request/acknowledge handshake, and it drives dbus during reads.

---
 rtl/th99_bus_if.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/th99_bus_if.sv
`default_nettype none
// ============================================================================
// Module : th99_bus_if
// Brief  : 8051-style multiplexed host-bus front end for the TH99CHLS core.
//          Synchronises the bus strobes, latches the 16-bit address and turns
//          bus cycles into write strobes and read request/ack handshakes.
// Rev    : 1.0  initial release
// ============================================================================
module th99_bus_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic [7:0]  abus,
    input  logic        ale,
    input  logic        r_n,
    input  logic        w_n,
    input  logic [7:0]  dbus_in,
    output logic [7:0]  dbus_out,
    output logic        dbus_oe,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic [7:0]  err_cnt
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_read  = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;

    // Strobe synchronisers plus one extra flop for edge detection
    logic [SYNC_STAGES-1:0] r_ale_sync;
    logic [SYNC_STAGES-1:0] r_r_n_sync;
    logic [SYNC_STAGES-1:0] r_w_n_sync;
    logic [SYNC_STAGES-1:0] r_cs_n_sync;
    logic                   r_ale_dly;
    logic                   r_r_n_dly;
    logic                   r_w_n_dly;

    // Bus pipelines are one stage longer so their tail lines up with the *_dly flops
    logic [SYNC_STAGES:0][7:0] r_abus_pipe;
    logic [SYNC_STAGES:0][7:0] r_dbus_pipe;

    logic [2:0]  r_state;
    logic [15:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_rd_acked;
    logic        r_rd_req;
    logic        r_wr_valid;
    logic [15:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_dbus_oe;
    logic [7:0]  r_err_cnt;

    logic [2:0]  w_state_nxt;
    logic        w_addr_load;
    logic        w_rd_start;
    logic        w_wr_commit;
    logic        w_err_inc;

    logic        w_ale_s;
    logic        w_r_n_s;
    logic        w_w_n_s;
    logic        w_cs_n_s;
    logic        w_ale_fall;
    logic        w_r_fall;
    logic        w_r_rise;
    logic        w_w_fall;
    logic        w_w_rise;
    logic [7:0]  w_abus_bv;
    logic [7:0]  w_dbus_bv;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_ale_sync  <= '0;
            r_r_n_sync  <= '1;
            r_w_n_sync  <= '1;
            r_cs_n_sync <= '1;
            r_ale_dly   <= 1'b0;
            r_r_n_dly   <= 1'b1;
            r_w_n_dly   <= 1'b1;
            r_abus_pipe <= '0;
            r_dbus_pipe <= '0;
        end else begin
            r_ale_sync  <= {r_ale_sync[SYNC_STAGES-2:0], ale};
            r_r_n_sync  <= {r_r_n_sync[SYNC_STAGES-2:0], r_n};
            r_w_n_sync  <= {r_w_n_sync[SYNC_STAGES-2:0], w_n};
            r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], cs_n};
            r_ale_dly   <= r_ale_sync[SYNC_STAGES-1];
            r_r_n_dly   <= r_r_n_sync[SYNC_STAGES-1];
            r_w_n_dly   <= r_w_n_sync[SYNC_STAGES-1];
            r_abus_pipe <= {r_abus_pipe[SYNC_STAGES-1:0], abus};
            r_dbus_pipe <= {r_dbus_pipe[SYNC_STAGES-1:0], dbus_in};
        end
    end

    assign w_ale_s    = r_ale_sync[SYNC_STAGES-1];
    assign w_r_n_s    = r_r_n_sync[SYNC_STAGES-1];
    assign w_w_n_s    = r_w_n_sync[SYNC_STAGES-1];
    assign w_cs_n_s   = r_cs_n_sync[SYNC_STAGES-1];
    assign w_ale_fall = r_ale_dly & ~w_ale_s;
    assign w_r_fall   = r_r_n_dly & ~w_r_n_s;
    assign w_r_rise   = ~r_r_n_dly & w_r_n_s;
    assign w_w_fall   = r_w_n_dly & ~w_w_n_s;
    assign w_w_rise   = ~r_w_n_dly & w_w_n_s;
    assign w_abus_bv  = r_abus_pipe[SYNC_STAGES];
    assign w_dbus_bv  = r_dbus_pipe[SYNC_STAGES];

    always_comb begin
        w_state_nxt = r_state;
        w_addr_load = 1'b0;
        w_rd_start  = 1'b0;
        w_wr_commit = 1'b0;
        w_err_inc   = 1'b0;
        // Deselect overrides everything and silently drops any access in flight
        if (w_cs_n_s) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_ale_s) w_state_nxt = c_st_addr;
                end
                c_st_addr: begin
                    if (w_ale_fall) begin
                        w_addr_load = 1'b1;
                        w_state_nxt = c_st_wait;
                    end
                end
                c_st_wait: begin
                    // One error per occurrence of both strobes going low together
                    if (!w_r_n_s && !w_w_n_s && (w_r_fall || w_w_fall)) begin
                        w_err_inc = 1'b1;
                    end else if (w_r_fall) begin
                        w_rd_start  = 1'b1;
                        w_state_nxt = c_st_read;
                    end else if (w_w_fall) begin
                        w_state_nxt = c_st_write;
                    end else if (w_ale_s) begin
                        w_state_nxt = c_st_addr;
                    end
                end
                c_st_read: begin
                    if (w_ale_s) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = c_st_addr;
                    end else if (w_r_rise) begin
                        w_state_nxt = c_st_wait;
                        if (!(r_rd_acked || rd_ack)) w_err_inc = 1'b1;
                    end
                end
                c_st_write: begin
                    if (w_ale_s) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = c_st_addr;
                    end else if (w_w_rise) begin
                        w_wr_commit = 1'b1;
                        w_state_nxt = c_st_wait;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_dout     <= '0;
            r_rd_acked <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_dbus_oe  <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_req   <= w_rd_start;
            r_wr_valid <= w_wr_commit;
            r_dbus_oe  <= (w_state_nxt == c_st_read);
            if (w_addr_load) r_addr <= {w_abus_bv, w_dbus_bv};
            if (w_wr_commit) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_dbus_bv;
            end
            if (w_rd_start) begin
                r_rd_acked <= 1'b0;
            end else if ((r_state == c_st_read) && rd_ack) begin
                r_rd_acked <= 1'b1;
            end
            if ((r_state == c_st_read) && rd_ack) r_dout <= rd_data;
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign dbus_out = r_dout;
    assign dbus_oe  = r_dbus_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_req   = r_rd_req;
    assign rd_addr  = r_addr;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
